uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART transmitter between kNumRequesters byte-stream sources.
- Each source sends a packet, a run of bytes ending with a `last` flag. Once a packet starts, the arbiter locks its grant to that source until the last byte is handed to the UART, or until the source stalls past a timeout.
- Sits between on-chip message producers (command responses, debug/status streams) and the uart tx_data/tx_valid/tx_ready port.

Parameters:
- kNumRequesters, 4, number of requesting sources (2..8).
- kIdleTimeout, 100000, clk cycles a granted source may stall mid-packet before the grant is revoked; 0 disables the timeout.
- kIdxWidth, $clog2(kNumRequesters), width of grant index (derived, not overridden).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- req_data  in  8*kNumRequesters  byte from source i at bits [8i+7:8i].
- req_valid  in  kNumRequesters  source i presents a byte.
- req_last  in  kNumRequesters  byte from source i is the final byte of its packet.
- req_ready  out  kNumRequesters  byte from source i accepted this cycle (when req_valid[i] is also high).
- uart_tx_data  out  8  byte to the UART transmitter.
- uart_tx_valid  out  1  byte available for the UART.
- uart_tx_ready  in  1  UART can accept a byte.
- grant_valid  out  1  a packet is currently granted.
- grant_id  out  kIdxWidth  index of the granted source (meaningful only while grant_valid is high).
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; hold register empty; timeout counter 0; last_grant = kNumRequesters-1, so source 0 has first priority.
- Handshake rules:
  - Byte transfer on either side occurs on a clk edge where valid && ready.
  - uart_tx_ready is a registered signal that may drop the cycle after acceptance; the arbiter must not depend on its value in any other cycle.
  - Sources must hold data/last stable while valid is high and ready is low.
- State IDLE:
  - grant_valid = 0; all req_ready = 0.
  - If any req_valid is set, select the first set bit scanning upward from last_grant+1, with wrap-around.
  - Register the selected index into grant_id, set grant_valid, and go to SEND. Arbitration latency is 1 cycle.
  - If no req_valid is set, stay in IDLE.
- State SEND, with granted index g and a 1-byte hold register (hold_full, hold_data, hold_last):
  - req_ready[g] = !hold_full; all other req_ready bits are 0.
  - On req_valid[g] && req_ready[g]: capture req_data[g] and req_last[g] into the hold register and set hold_full. The byte is presented to the UART the next cycle.
  - uart_tx_valid = hold_full; uart_tx_data = hold_data. Both are registered outputs with no combinational path from req_*.
  - On uart_tx_valid && uart_tx_ready: clear hold_full.
    - If hold_last is set: last_grant <= g, grant_valid <= 0, go to IDLE.
  - Load and drain never occur in the same cycle, because ready requires an empty hold register. Peak throughput is 1 byte per 2 cycles, far above the UART byte rate.
- Timeout (kIdleTimeout > 0):
  - Counter increments each SEND cycle where hold_full == 0 and req_valid[g] == 0.
  - Counter clears on any byte captured and on entering SEND.
  - On reaching kIdleTimeout: pulse timeout_pulse for 1 cycle, set last_grant <= g, drop the grant, go to IDLE.
  - A byte already in the hold register is never discarded; the timeout is only counted while the hold register is empty.
- A source deasserting valid mid-packet is legal. The grant is kept until req_last or timeout, and no other source interleaves bytes.
- req_last on a single-byte packet is legal: grant, one byte, then release.
- All requesters asserting continuously: strict rotation 0,1,2,3,0... per packet, never per byte.
- Reset asserted mid-packet: everything returns to reset values immediately. Any half-sent packet is lost; the UART shares rst_n.
- req_data/req_last of non-granted sources are ignored.
- Counter width is $clog2(kIdleTimeout+1); compares are unsigned.

Decomposition:
- Shared package uart_pkg:
  - typedef arb_state_t {IDLE, SEND}.
  - localparam kUartDataWidth = 8.
  - localparam kClkHz = 100_000_000 (used by callers to size kIdleTimeout).
- One sub-module rr_pick (combinational):
  - Inputs: req vector, last_grant.
  - Outputs: any, next index.
  - Reused later by other shared-resource arbiters.

Test Plan:
- Reset then source 2 sends single byte 0x41 with last -> grant_id=2 one cycle later; uart_tx_valid with 0x41; grant_valid drops after UART acceptance; timeout_pulse stays 0.
- Sources 0 and 1 both hold 3-byte packets {0x10,0x11,0x12} and {0x20,0x21,0x22} -> UART sees 0x10,0x11,0x12,0x20,0x21,0x22 with no interleave; req_ready[1] stays 0 during packet 0.
- All 4 sources continuously present 1-byte packets -> grant order 0,1,2,3,0,1 over six packets.
- Source 1 sends 0x55 without last, then stalls, kIdleTimeout=20 -> exactly 20 idle cycles after the UART drains 0x55, timeout_pulse pulses once and grant drops; next grant goes to source 2 if requesting.
- Model the UART holding tx_ready low for 1000 cycles with a byte in the hold register -> uart_tx_valid and uart_tx_data stay stable; req_ready[g]=0; no timeout fires.
- rst_n pulsed low mid-packet on source 3 -> all outputs 0 asynchronously; after release, source 0 wins first even with sources 0 and 3 both requesting.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and its arbiters.
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  localparam int kUartDataWidth = 8;
  localparam int kClkHz         = 100_000_000;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from last_grant+1, with wrap-around.
`default_nettype none
`timescale 1ns/1ps

module rr_pick #(
  parameter int kNumReq   = 4,
  parameter int kIdxWidth = $clog2(kNumReq)
) (
  input  logic [kNumReq-1:0]   req,
  input  logic [kIdxWidth-1:0] last_grant,
  output logic                 any,
  output logic [kIdxWidth-1:0] next_idx
);

  logic found;
  int   k;

  always_comb begin
    any      = |req;
    next_idx = '0;
    found    = 1'b0;
    k        = 0;
    for (int i = 1; i <= kNumReq; i++) begin
      k = (int'(last_grant) + i) % kNumReq;
      if (!found && req[k]) begin
        found    = 1'b1;
        next_idx = kIdxWidth'(k);
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter among several byte-stream sources.
`default_nettype none
`timescale 1ns/1ps

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int kNumRequesters = 4,
  parameter int kIdleTimeout   = 100000,
  parameter int kIdxWidth      = $clog2(kNumRequesters)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [kUartDataWidth*kNumRequesters-1:0] req_data,
  input  logic [kNumRequesters-1:0]                req_valid,
  input  logic [kNumRequesters-1:0]                req_last,
  output logic [kNumRequesters-1:0]                req_ready,
  output logic [kUartDataWidth-1:0]                uart_tx_data,
  output logic                                     uart_tx_valid,
  input  logic                                     uart_tx_ready,
  output logic                                     grant_valid,
  output logic [kIdxWidth-1:0]                     grant_id,
  output logic                                     timeout_pulse
);

  localparam int kCntWidth = (kIdleTimeout > 0) ? $clog2(kIdleTimeout + 1) : 1;
  localparam logic [kCntWidth-1:0] kCntLast =
      (kIdleTimeout > 0) ? kCntWidth'(kIdleTimeout - 1) : '0;

  arb_state_t                 state;
  arb_state_t                 state_next;
  logic [kIdxWidth-1:0]       last_grant;
  logic [kIdxWidth-1:0]       pick_idx;
  logic                       pick_any;
  logic                       hold_full;
  logic                       hold_last;
  logic [kUartDataWidth-1:0]  hold_data;
  logic [kCntWidth-1:0]       idle_cnt;

  logic start;
  logic capture;
  logic drain;
  logic done;
  logic idle_tick;
  logic timeout_hit;

  rr_pick #(
    .kNumReq   (kNumRequesters),
    .kIdxWidth (kIdxWidth)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .next_idx   (pick_idx)
  );

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    capture     = 1'b0;
    drain       = 1'b0;
    done        = 1'b0;
    idle_tick   = 1'b0;
    timeout_hit = 1'b0;
    req_ready   = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          start      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        // The hold register is one byte deep, so load and drain never overlap.
        req_ready[grant_id] = !hold_full;
        capture   = req_valid[grant_id] && !hold_full;
        drain     = hold_full && uart_tx_ready;
        idle_tick = !hold_full && !req_valid[grant_id];
        if ((kIdleTimeout > 0) && idle_tick && (idle_cnt == kCntLast)) begin
          timeout_hit = 1'b1;
        end
        if ((drain && hold_last) || timeout_hit) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      last_grant    <= kIdxWidth'(kNumRequesters - 1);
      hold_full     <= 1'b0;
      hold_last     <= 1'b0;
      hold_data     <= '0;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      timeout_pulse <= timeout_hit;
      if (start) begin
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
        idle_cnt    <= '0;
      end
      if (capture) begin
        hold_full <= 1'b1;
        hold_data <= req_data[int'(grant_id)*kUartDataWidth +: kUartDataWidth];
        hold_last <= req_last[grant_id];
        idle_cnt  <= '0;
      end else if (idle_tick && (kIdleTimeout > 0)) begin
        idle_cnt <= timeout_hit ? '0 : idle_cnt + 1'b1;
      end
      if (drain) begin
        hold_full <= 1'b0;
      end
      if (done) begin
        grant_valid <= 1'b0;
        last_grant  <= grant_id;
      end
    end
  end

  assign uart_tx_valid = hold_full;
  assign uart_tx_data  = hold_data;

endmodule : uart_tx_arbiter

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source packet buffers, a UART sink and a vector table for rotation.
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int kN = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [8*kN-1:0]  req_data;
  logic [kN-1:0]    req_valid;
  logic [kN-1:0]    req_last;
  logic [kN-1:0]    req_ready;
  logic [7:0]       uart_tx_data;
  logic             uart_tx_valid;
  logic             uart_tx_ready;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic             timeout_pulse;

  uart_tx_arbiter #(
    .kNumRequesters (kN),
    .kIdleTimeout   (20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source model: each entry is {last, data}.
  logic [8:0] sbuf [kN][64];
  int         shead [kN];
  int         stail [kN];

  logic [7:0] rx_data [256];
  logic [1:0] rx_gid  [256];
  int         rx_n = 0;
  int         tp_count = 0;
  int         ready_viol = 0;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input logic last, input logic [7:0] d);
    sbuf[s][stail[s]] = {last, d};
    stail[s]++;
  endtask

  task automatic drive();
    logic [8*kN-1:0] d;
    logic [kN-1:0]   v;
    logic [kN-1:0]   l;
    logic [kN-1:0]   allowed;
    d = '0; v = '0; l = '0;
    for (int s = 0; s < kN; s++) begin
      if (shead[s] < stail[s]) begin
        v[s]         = 1'b1;
        d[8*s +: 8]  = sbuf[s][shead[s]][7:0];
        l[s]         = sbuf[s][shead[s]][8];
      end
    end
    req_data  = d;
    req_valid = v;
    req_last  = l;
    #1;
    allowed = grant_valid ? (4'b0001 << grant_id) : 4'b0000;
    if ((req_ready & ~allowed) != 0) ready_viol++;
    if (timeout_pulse) tp_count++;
  endtask

  task automatic advance();
    for (int s = 0; s < kN; s++) begin
      if (req_valid[s] && req_ready[s]) shead[s]++;
    end
    if (uart_tx_valid && uart_tx_ready) begin
      rx_data[rx_n] = uart_tx_data;
      rx_gid[rx_n]  = grant_id;
      rx_n++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_rx(input int target);
    int k;
    k = 0;
    while (rx_n < target && k < 200) begin
      drive();
      advance();
      k++;
    end
    check("rx_wait", rx_n, target);
  endtask

  initial begin
    int base;
    int idle;
    int bad;
    logic [7:0] exp2 [6];
    logic [1:0] gid2 [6];

    exp2 = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    gid2 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

    // {mask of sources loaded with a 1-byte packet, expected grant, expected byte}
    vecs[0]  = '{4'b1111, 2'd2, 8'hA2};
    vecs[1]  = '{4'b0000, 2'd3, 8'hA3};
    vecs[2]  = '{4'b0000, 2'd0, 8'hA0};
    vecs[3]  = '{4'b0100, 2'd1, 8'hA1};
    vecs[4]  = '{4'b1001, 2'd2, 8'hA2};
    vecs[5]  = '{4'b0000, 2'd3, 8'hA3};
    vecs[6]  = '{4'b0010, 2'd0, 8'hA0};
    vecs[7]  = '{4'b0000, 2'd1, 8'hA1};
    vecs[8]  = '{4'b0001, 2'd0, 8'hA0};
    vecs[9]  = '{4'b1000, 2'd3, 8'hA3};
    vecs[10] = '{4'b1111, 2'd0, 8'hA0};
    vecs[11] = '{4'b0001, 2'd1, 8'hA1};
    vecs[12] = '{4'b0010, 2'd2, 8'hA2};
    vecs[13] = '{4'b0100, 2'd3, 8'hA3};
    vecs[14] = '{4'b1000, 2'd0, 8'hA0};
    vecs[15] = '{4'b0000, 2'd1, 8'hA1};
    vecs[16] = '{4'b0000, 2'd2, 8'hA2};
    vecs[17] = '{4'b0000, 2'd3, 8'hA3};

    for (int s = 0; s < kN; s++) begin
      shead[s] = 0;
      stail[s] = 0;
    end
    rst_n = 1'b0;
    req_data = '0;
    req_valid = '0;
    req_last = '0;
    uart_tx_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_tx_valid", uart_tx_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_timeout", timeout_pulse, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-byte packet from source 2.
    push(2, 1'b1, 8'h41);
    drive();
    check("t1_idle_gv", grant_valid, 0);
    check("t1_idle_ready", req_ready, 0);
    advance();
    drive();
    check("t1_gv", grant_valid, 1);
    check("t1_gid", grant_id, 2);
    check("t1_ready", req_ready, 4'b0100);
    check("t1_txv_early", uart_tx_valid, 0);
    advance();
    drive();
    check("t1_txv", uart_tx_valid, 1);
    check("t1_txd", uart_tx_data, 8'h41);
    check("t1_ready_full", req_ready, 0);
    advance();
    drive();
    check("t1_release_gv", grant_valid, 0);
    check("t1_release_txv", uart_tx_valid, 0);
    advance();
    check("t1_no_timeout", tp_count, 0);

    // Two 3-byte packets must not interleave.
    base = rx_n;
    push(0, 1'b0, 8'h10); push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h12);
    push(1, 1'b0, 8'h20); push(1, 1'b0, 8'h21); push(1, 1'b1, 8'h22);
    run_until_rx(base + 6);
    for (int i = 0; i < 6; i++) begin
      check("t2_data", rx_data[base + i], exp2[i]);
      check("t2_gid", rx_gid[base + i], gid2[i]);
    end
    check("t2_ready_onehot", ready_viol, 0);

    // Rotation table, one packet per vector.
    for (int v = 0; v < 18; v++) begin
      for (int s = 0; s < kN; s++) begin
        if (vecs[v].mask[s]) push(s, 1'b1, 8'hA0 | 8'(s));
      end
      base = rx_n;
      run_until_rx(base + 1);
      check("vec_gid", rx_gid[base], vecs[v].exp_grant);
      check("vec_data", rx_data[base], vecs[v].exp_data);
    end

    // Source 1 stalls mid-packet; source 2 waits for the revoked grant.
    base = rx_n;
    push(1, 1'b0, 8'h55);
    run_until_rx(base + 1);
    check("to_data", rx_data[base], 8'h55);
    check("to_gid", rx_gid[base], 1);
    push(2, 1'b1, 8'h66);
    idle = 0;
    drive();
    while (!timeout_pulse && idle < 100) begin
      idle++;
      advance();
      drive();
    end
    check("to_idle_cycles", idle, 20);
    check("to_gv_dropped", grant_valid, 0);
    advance();
    drive();
    check("to_pulse_once", timeout_pulse, 0);
    check("to_next_gv", grant_valid, 1);
    check("to_next_gid", grant_id, 2);
    advance();
    base = rx_n;
    run_until_rx(base + 1);
    check("to_next_data", rx_data[base], 8'h66);
    check("to_pulse_count", tp_count, 1);

    // UART back-pressure for 1000 cycles with a byte held.
    uart_tx_ready = 1'b0;
    push(3, 1'b0, 8'h77);
    push(3, 1'b1, 8'h78);
    idle = 0;
    drive();
    while (!uart_tx_valid && idle < 10) begin
      idle++;
      advance();
      drive();
    end
    check("st_gid", grant_id, 3);
    advance();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      drive();
      if (!uart_tx_valid || uart_tx_data != 8'h77 || req_ready != 0 || timeout_pulse) bad++;
      advance();
    end
    check("st_stable", bad, 0);
    uart_tx_ready = 1'b1;
    base = rx_n;
    run_until_rx(base + 2);
    check("st_data0", rx_data[base], 8'h77);
    check("st_data1", rx_data[base + 1], 8'h78);
    check("st_no_timeout", tp_count, 1);

    // Asynchronous reset in the middle of a source-3 packet.
    base = rx_n;
    push(3, 1'b0, 8'h31); push(3, 1'b0, 8'h32); push(3, 1'b1, 8'h33);
    run_until_rx(base + 1);
    check("rs_first", rx_data[base], 8'h31);
    drive();
    rst_n = 1'b0;
    #1;
    check("rs_gv", grant_valid, 0);
    check("rs_gid", grant_id, 0);
    check("rs_txv", uart_tx_valid, 0);
    check("rs_txd", uart_tx_data, 0);
    check("rs_ready", req_ready, 0);
    check("rs_timeout", timeout_pulse, 0);
    @(negedge clk);
    push(0, 1'b1, 8'h01);
    rst_n = 1'b1;
    drive();
    check("rs_idle", grant_valid, 0);
    advance();
    drive();
    check("rs_regrant_gv", grant_valid, 1);
    check("rs_regrant_gid", grant_id, 0);
    advance();
    base = rx_n;
    run_until_rx(base + 1);
    check("rs_regrant_data", rx_data[base], 8'h01);
    check("final_ready_onehot", ready_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

`default_nettype wire
